grf_scoreboard: RTL and testbench

Parametrised general register file with N combinational read ports, one write port, write-to-read bypass and a per-register busy scoreboard. It replaces the fixed 2-read GRF in the pipelined datapath. Decode reads operands and pending status in the same cycle, issue marks a destination pending, and writeback fills the register and clears the pending status.

---
 rtl/grf_pkg.sv | 24 ++
 rtl/grf_scoreboard_if.sv | 34 +++
 rtl/grf_busy_table.sv | 75 +++++++
 rtl/grf_scoreboard.sv | 88 ++++++++
 tb/tb_grf_scoreboard.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/grf_pkg.sv
// Shared constants and helpers for the general register file with busy scoreboard.
// Optional trace output is controlled by the GRF_TRACE_EN macro (see grf_scoreboard.sv).
package grf_pkg;

    localparam int unsigned GRF_WIDTH   = 32;
    localparam int unsigned GRF_ADDR_W  = 5;
    localparam int unsigned ZERO_REG    = 0;

    // Upper bounds for the generic field extractor: up to 4 ports of up to 64 bits.
    localparam int unsigned FIELD_MAX_W = 64;
    localparam int unsigned VEC_MAX_W   = 256;

    // Return field k of width w from a packed multi-port vector (port k at [k*w +: w]).
    function automatic logic [FIELD_MAX_W-1:0] field_extract(
        input logic [VEC_MAX_W-1:0] vec,
        input int unsigned          k,
        input int unsigned          w
    );
        logic [FIELD_MAX_W-1:0] mask;
        mask = (FIELD_MAX_W'(1) << w) - FIELD_MAX_W'(1);
        return FIELD_MAX_W'(vec >> (k * w)) & mask;
    endfunction

endpackage

// File: rtl/grf_scoreboard_if.sv
// Bus bundle for grf_scoreboard: read ports, write port, issue/flush and status.
interface grf_scoreboard_if
    import grf_pkg::*;
#(
    parameter int unsigned WIDTH  = GRF_WIDTH,
    parameter int unsigned ADDR_W = GRF_ADDR_W,
    parameter int unsigned NRD    = 2
);

    logic [31:0]           pc;
    logic [NRD*ADDR_W-1:0] ra;
    logic [NRD*WIDTH-1:0]  rd;
    logic [NRD-1:0]        rbusy;
    logic                  we;
    logic [ADDR_W-1:0]     wa;
    logic [WIDTH-1:0]      wd;
    logic                  set_en;
    logic [ADDR_W-1:0]     set_a;
    logic                  flush;
    logic [ADDR_W:0]       busy_cnt;

    // Pipeline side: drives addresses, write data and issue/flush.
    modport master (
        output pc, ra, we, wa, wd, set_en, set_a, flush,
        input  rd, rbusy, busy_cnt
    );

    // Register file side.
    modport slave (
        input  pc, ra, we, wa, wd, set_en, set_a, flush,
        output rd, rbusy, busy_cnt
    );

endinterface

// File: rtl/grf_busy_table.sv
// Per-register busy scoreboard with incrementally maintained population count.
// Priority per edge: rst > flush (then set still applies) > clear > set (set wins on same address).
module grf_busy_table
    import grf_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       clr_en,
    input  logic [$clog2(DEPTH)-1:0]   clr_a,
    input  logic                       set_en,
    input  logic [$clog2(DEPTH)-1:0]   set_a,
    output logic [DEPTH-1:0]           busy,
    output logic [$clog2(DEPTH):0]     busy_cnt
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [DEPTH-1:0] r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_set_hit;
    logic             w_clr_hit;
    logic             w_inc;
    logic             w_dec;

    assign w_set_hit = set_en && (set_a != AW'(ZERO_REG));
    assign w_clr_hit = clr_en && (clr_a != AW'(ZERO_REG));

    // Next busy vector and count; the count moves by at most one per edge except on flush.
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_cnt;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        if (flush) begin
            w_busy_nxt = '0;
            w_cnt_nxt  = '0;
            if (w_set_hit) begin
                w_busy_nxt[set_a] = 1'b1;
                w_cnt_nxt         = CNT_W'(1);
            end
        end else begin
            if (w_clr_hit) begin
                w_busy_nxt[clr_a] = 1'b0;
            end
            if (w_set_hit) begin
                w_busy_nxt[set_a] = 1'b1;
            end
            // A clear on the address being set is overridden, so it must not decrement.
            w_inc     = w_set_hit && !r_busy[set_a];
            w_dec     = w_clr_hit && r_busy[clr_a] && !(w_set_hit && (set_a == clr_a));
            w_cnt_nxt = r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
        end
    end

    // Busy state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule

// File: rtl/grf_scoreboard.sv
// General register file: NRD combinational read ports with write bypass, one write port,
// and a busy scoreboard. Define GRF_TRACE_EN to print a line for every performed write.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int unsigned WIDTH  = GRF_WIDTH,
    parameter int unsigned ADDR_W = GRF_ADDR_W,
    parameter int unsigned NRD    = 2
) (
    input  logic              clk,
    input  logic              rst,
    grf_scoreboard_if.slave   bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]     r_regs [DEPTH];
    logic [DEPTH-1:0]     w_busy;
    logic [ADDR_W:0]      w_busy_cnt;
    logic                 w_wr_hit;
    logic [NRD*WIDTH-1:0] w_rd_flat;
    logic [NRD-1:0]       w_rbusy;
    logic [ADDR_W-1:0]    w_a;

    assign w_wr_hit = bus.we && (bus.wa != ADDR_W'(ZERO_REG));

    // Data array; register 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    grf_busy_table #(
        .DEPTH (DEPTH)
    ) u_busy (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .clr_en   (bus.we),
        .clr_a    (bus.wa),
        .set_en   (bus.set_en),
        .set_a    (bus.set_a),
        .busy     (w_busy),
        .busy_cnt (w_busy_cnt)
    );

    // Read muxes: zero register, then same-cycle write bypass, then stored value and busy bit.
    always_comb begin
        w_rd_flat = '0;
        w_rbusy   = '0;
        w_a       = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            w_a = ADDR_W'(field_extract(VEC_MAX_W'(bus.ra), k, ADDR_W));
            if (w_a == ADDR_W'(ZERO_REG)) begin
                w_rd_flat[k*WIDTH +: WIDTH] = '0;
                w_rbusy[k]                  = 1'b0;
            end else if (bus.we && (bus.wa == w_a)) begin
                w_rd_flat[k*WIDTH +: WIDTH] = bus.wd;
                w_rbusy[k]                  = 1'b0;
            end else begin
                w_rd_flat[k*WIDTH +: WIDTH] = r_regs[w_a];
                w_rbusy[k]                  = w_busy[w_a];
            end
        end
    end

    assign bus.rd       = w_rd_flat;
    assign bus.rbusy    = w_rbusy;
    assign bus.busy_cnt = w_busy_cnt;

`ifdef GRF_TRACE_EN
    // Write trace in the checker's format.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_hit) begin
            $display("@%h: $%2d <= %h", bus.pc, bus.wa, bus.wd);
        end
    end
`else
    logic w_unused_pc;
    assign w_unused_pc = ^bus.pc;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Bench for grf_scoreboard (NRD=3): directed vector table plus randomized run against a model.
module tb_grf_scoreboard;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 3;

    logic clk;
    logic rst;

    grf_scoreboard_if #(.WIDTH(W), .ADDR_W(AW), .NRD(NR)) bus ();

    grf_scoreboard #(.WIDTH(W), .ADDR_W(AW), .NRD(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: plain arrays updated from the architectural rules.
    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        se;
        logic [4:0]  sa;
        logic        fl;
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] e0, e1, e2;
        logic [2:0]  eb;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic se, input logic [4:0] sa, input logic fl,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        rst        = r;
        bus.pc     = 32'h3000 + {27'd0, wa};
        bus.we     = we;
        bus.wa     = wa;
        bus.wd     = wd;
        bus.set_en = se;
        bus.set_a  = sa;
        bus.flush  = fl;
        bus.ra     = {a2, a1, a0};
    endtask

    function automatic int popcount_model();
        int c = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    // Advance through one rising edge, updating the model from the inputs present at the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 0;
            end
        end else begin
            if (bus.we && bus.wa != 0) m_mem[bus.wa] = bus.wd;
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (bus.we && bus.wa != 0) begin
                m_busy[bus.wa] = 0;
            end
            if (bus.set_en && bus.set_a != 0) m_busy[bus.set_a] = 1;
        end
        #1;
    endtask

    function automatic logic [4:0] port_addr(input int k);
        logic [14:0] v;
        v = bus.ra;
        return v[k*5 +: 5];
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return '0;
        if (bus.we && bus.wa == a) return bus.wd;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (bus.we && bus.wa == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic se, input logic [4:0] sa, input logic fl,
                                input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                                input logic [2:0] eb, input logic [5:0] ecnt);
        vec_t v;
        v.rst = r; v.we = we; v.wa = wa; v.wd = wd; v.se = se; v.sa = sa; v.fl = fl;
        v.ra0 = a0; v.ra1 = a1; v.ra2 = a2; v.e0 = e0; v.e1 = e1; v.e2 = e2;
        v.eb = eb; v.ecnt = ecnt;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] act;
        // Directed vectors: {rst,we,wa,wd,set_en,set_a,flush, ra0..2, exp rd0..2, exp rbusy, busy_cnt after edge}
        tbl.push_back(mk(0,1, 5,32'hDEADBEEF,0, 0,0,  5, 0, 0, 32'hDEADBEEF,0,0, 3'b000,0));
        tbl.push_back(mk(0,0, 0,32'h0,       0, 0,0,  5, 5, 5, 32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF, 3'b000,0));
        tbl.push_back(mk(0,1, 0,32'h1234,    0, 0,0,  0, 0, 0, 0,0,0, 3'b000,0));
        tbl.push_back(mk(0,0, 0,32'h0,       0, 0,0,  0, 5, 0, 0,32'hDEADBEEF,0, 3'b000,0));
        tbl.push_back(mk(0,0, 0,32'h0,       1, 7,0,  0, 7, 0, 0,0,0, 3'b000,1));
        tbl.push_back(mk(0,0, 0,32'h0,       0, 0,0,  0, 7, 7, 0,0,0, 3'b110,1));
        tbl.push_back(mk(0,1, 7,32'h55,      0, 0,0,  0, 7, 7, 0,32'h55,32'h55, 3'b000,0));
        tbl.push_back(mk(0,0, 0,32'h0,       0, 0,0,  7, 0, 0, 32'h55,0,0, 3'b000,0));
        tbl.push_back(mk(0,0, 0,32'h0,       1, 9,0,  9, 0, 0, 0,0,0, 3'b000,1));
        tbl.push_back(mk(0,1, 9,32'hA5A5A5A5,1, 9,0,  9, 9, 0, 32'hA5A5A5A5,32'hA5A5A5A5,0, 3'b000,1));
        tbl.push_back(mk(0,0, 0,32'h0,       0, 0,0,  9, 0, 0, 32'hA5A5A5A5,0,0, 3'b001,1));
        tbl.push_back(mk(0,0, 0,32'h0,       0, 0,1,  9, 0, 0, 32'hA5A5A5A5,0,0, 3'b001,0));
        tbl.push_back(mk(0,0, 0,32'h0,       1, 3,0,  9, 0, 0, 32'hA5A5A5A5,0,0, 3'b000,1));
        tbl.push_back(mk(0,0, 0,32'h0,       1, 4,0,  3, 0, 0, 0,0,0, 3'b001,2));
        tbl.push_back(mk(0,0, 0,32'h0,       1, 6,0,  3, 4, 0, 0,0,0, 3'b011,3));
        tbl.push_back(mk(0,0, 0,32'h0,       1,10,1,  3, 4, 6, 0,0,0, 3'b111,1));
        tbl.push_back(mk(0,0, 0,32'h0,       0, 0,0, 10, 3, 5, 0,0,32'hDEADBEEF, 3'b001,1));
        tbl.push_back(mk(0,0, 0,32'h0,       0, 0,0,  9, 7, 6, 32'hA5A5A5A5,32'h55,0, 3'b000,1));
        tbl.push_back(mk(1,1,31,32'h1,       1,12,0, 10, 5,31, 0,32'hDEADBEEF,32'h1, 3'b001,0));
        tbl.push_back(mk(0,0, 0,32'h0,       0, 0,0, 10, 5,31, 0,0,0, 3'b000,0));
        tbl.push_back(mk(0,0, 0,32'h0,       0, 0,0,  9, 7,12, 0,0,0, 3'b000,0));

        // Reset and sweep every address on every port.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 0;
        end
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_busy_cnt", {58'd0, bus.busy_cnt}, 64'd0);
        for (int a = 0; a < 32; a++) begin
            bus.ra = {a[4:0], a[4:0], a[4:0]};
            #1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("reset_rd a=%0d k=%0d", a, k), {32'd0, bus.rd[k*32 +: 32]}, 64'd0);
                chk($sformatf("reset_rbusy a=%0d k=%0d", a, k), {63'd0, bus.rbusy[k]}, 64'd0);
            end
        end
        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].se, tbl[i].sa, tbl[i].fl,
                  tbl[i].ra0, tbl[i].ra1, tbl[i].ra2);
            @(negedge clk);
            act = bus.rd[31:0];
            chk($sformatf("vec%0d rd0", i), {32'd0, act}, {32'd0, tbl[i].e0});
            act = bus.rd[63:32];
            chk($sformatf("vec%0d rd1", i), {32'd0, act}, {32'd0, tbl[i].e1});
            act = bus.rd[95:64];
            chk($sformatf("vec%0d rd2", i), {32'd0, act}, {32'd0, tbl[i].e2});
            chk($sformatf("vec%0d rbusy", i), {61'd0, bus.rbusy}, {61'd0, tbl[i].eb});
            tick();
            chk($sformatf("vec%0d busy_cnt", i), {58'd0, bus.busy_cnt}, {58'd0, tbl[i].ecnt});
        end

        // Randomized run against the model; first cycle resets both sides.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int n = 0; n < 800; n++) begin
            logic        r, we, se, fl;
            logic [4:0]  wa, sa;
            logic [4:0]  a [3];
            r  = ($urandom_range(0, 99) == 0);
            we = $urandom_range(0, 1);
            wa = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) wa = 5'($urandom_range(0, 7));
            se = $urandom_range(0, 1);
            sa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            fl = ($urandom_range(0, 24) == 0);
            for (int k = 0; k < 3; k++) begin
                a[k] = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            end
            drive(r, we, wa, $urandom, se, sa, fl, a[0], a[1], a[2]);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                logic [4:0] pa;
                pa = port_addr(k);
                chk($sformatf("rnd%0d rd%0d a=%0d", n, k, pa), {32'd0, bus.rd[k*32 +: 32]}, {32'd0, exp_rd(pa)});
                chk($sformatf("rnd%0d rbusy%0d a=%0d", n, k, pa), {63'd0, bus.rbusy[k]}, {63'd0, exp_busy(pa)});
            end
            tick();
            chk($sformatf("rnd%0d busy_cnt", n), {58'd0, bus.busy_cnt}, 64'(popcount_model()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
